// File: rtl/period_meter_if.sv
// Signal bundle between a period_meter and the logic that drives and observes it.
// The master drives the measured wave and soft restart; the slave reports edges, periods and stalls.
interface period_meter_if #(
    parameter int CNT_W = 32
);
    logic             sig_in;
    logic             clear;
    logic             edge_tick;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             stalled;

    modport master (
        output sig_in,
        output clear,
        input  edge_tick,
        input  period_out,
        input  period_valid,
        input  stalled
    );

    modport slave (
        input  sig_in,
        input  clear,
        output edge_tick,
        output period_out,
        output period_valid,
        output stalled
    );
endinterface

// File: rtl/period_meter.sv
// Measures the period of a slow square wave in clk cycles and flags the input as stalled
// when no rising edge arrives within TIMEOUT cycles.
module period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic          clk,
    input  logic          rst,
    period_meter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STALLED
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state, state_next;
    logic             sync1, sync2, prev;
    logic             rise;
    logic [CNT_W-1:0] counter, counter_next;
    logic [CNT_W-1:0] period_q, period_next;
    logic             edge_tick_q, valid_q, valid_next;
    logic             stalled_q, stalled_next;

    assign rise = sync2 & ~prev;

    // Soft clear behaves exactly like reset so a partial count is never reported.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            prev        <= 1'b0;
            state       <= IDLE;
            counter     <= '0;
            edge_tick_q <= 1'b0;
            valid_q     <= 1'b0;
            period_q    <= '0;
            stalled_q   <= 1'b0;
        end else begin
            sync1       <= bus.sig_in;
            sync2       <= sync1;
            prev        <= sync2;
            state       <= state_next;
            counter     <= counter_next;
            edge_tick_q <= rise;
            valid_q     <= valid_next;
            period_q    <= period_next;
            stalled_q   <= stalled_next;
        end
    end

    // A rise always wins over the timeout; only a rise seen from MEASURE has a known interval.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        valid_next   = 1'b0;
        period_next  = period_q;
        stalled_next = stalled_q;
        case (state)
            IDLE, MEASURE: begin
                if (rise) begin
                    state_next   = MEASURE;
                    counter_next = '0;
                    stalled_next = 1'b0;
                    if (state == MEASURE) begin
                        valid_next  = 1'b1;
                        period_next = counter + ONE;
                    end
                end else if (counter == TIMEOUT_M1) begin
                    state_next   = STALLED;
                    stalled_next = 1'b1;
                end else begin
                    counter_next = counter + ONE;
                end
            end
            STALLED: begin
                if (rise) begin
                    state_next   = MEASURE;
                    counter_next = '0;
                    stalled_next = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
            end
        endcase
    end

    assign bus.edge_tick    = edge_tick_q;
    assign bus.period_valid = valid_q;
    assign bus.period_out   = period_q;
    assign bus.stalled      = stalled_q;
endmodule

// File: tb/tb_period_meter.sv
// Drives two period_meter instances (TIMEOUT 20 and 10) with the same wave and compares every
// cycle against a reference built from the sampled input history and rise timestamps.
module tb_period_meter;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic clear = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    period_meter_if #(.CNT_W(CNT_W)) bus0 ();
    period_meter_if #(.CNT_W(CNT_W)) bus1 ();

    assign bus0.sig_in = sig_in;
    assign bus0.clear  = clear;
    assign bus1.sig_in = sig_in;
    assign bus1.clear  = clear;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(20)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(10)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Reference state: samples of sig_in per clk edge plus timestamps of rises per instance.
    int   tmo [2] = '{20, 10};
    int   cyc = 0;
    logic samp [$];
    logic tick_m;
    int   ref_t [2];
    int   last_t [2];
    bit   armed_m [2];
    bit   stall_m [2];
    bit   valid_m [2];
    int   period_m [2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
        end
    endtask

    task automatic updateModel(input logic s, input logic c, input logic r);
        if (r || c) begin
            samp   = '{1'b0, 1'b0, 1'b0, 1'b0};
            tick_m = 1'b0;
            for (int i = 0; i < 2; i++) begin
                ref_t[i]    = cyc;
                last_t[i]   = cyc;
                armed_m[i]  = 1'b0;
                stall_m[i]  = 1'b0;
                valid_m[i]  = 1'b0;
                period_m[i] = 0;
            end
        end else begin
            samp.push_back(s);
            if (samp.size() > 8) void'(samp.pop_front());
            tick_m = samp[samp.size()-3] && !samp[samp.size()-4];
            for (int i = 0; i < 2; i++) begin
                valid_m[i] = 1'b0;
                if (tick_m) begin
                    if (armed_m[i]) begin
                        valid_m[i]  = 1'b1;
                        period_m[i] = cyc - last_t[i];
                    end
                    last_t[i]  = cyc;
                    ref_t[i]   = cyc;
                    armed_m[i] = 1'b1;
                    stall_m[i] = 1'b0;
                end else if (!stall_m[i] && (cyc - ref_t[i] == tmo[i])) begin
                    stall_m[i] = 1'b1;
                    armed_m[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic r);
        logic             ob_tick [2];
        logic             ob_valid [2];
        logic             ob_stall [2];
        logic [CNT_W-1:0] ob_period [2];
        @(negedge clk);
        sig_in = s;
        clear  = c;
        rst    = r;
        @(posedge clk);
        cyc++;
        updateModel(s, c, r);
        #1;
        ob_tick[0]   = bus0.edge_tick;
        ob_valid[0]  = bus0.period_valid;
        ob_stall[0]  = bus0.stalled;
        ob_period[0] = bus0.period_out;
        ob_tick[1]   = bus1.edge_tick;
        ob_valid[1]  = bus1.period_valid;
        ob_stall[1]  = bus1.stalled;
        ob_period[1] = bus1.period_out;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("edge_tick[T=%0d]", tmo[i]), 32'(ob_tick[i]), 32'(tick_m));
            checkOutput($sformatf("period_valid[T=%0d]", tmo[i]), 32'(ob_valid[i]), 32'(valid_m[i]));
            checkOutput($sformatf("stalled[T=%0d]", tmo[i]), 32'(ob_stall[i]), 32'(stall_m[i]));
            checkOutput($sformatf("period_out[T=%0d]", tmo[i]), 32'(ob_period[i]), 32'(period_m[i]));
        end
    endtask

    task automatic hold(input logic s, input int cycles);
        repeat (cycles) applyStimulus(s, 1'b0, 1'b0);
    endtask

    task automatic wave(input int hi, input int lo, input int periods);
        repeat (periods) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    initial begin
        $display("[TB] starting period_meter bench");
        for (int k = 0; k < 3; k++) applyStimulus(1'(k % 2), 1'b0, 1'b1);
        hold(1'b0, 2);

        // Period 10: exact for T=20, rise-versus-timeout race for T=10.
        wave(5, 5, 8);
        hold(1'b0, 30);
        wave(5, 5, 4);

        // Period 11: measured by T=20, stalls and recovers each time for T=10.
        wave(6, 5, 4);
        hold(1'b0, 3);

        // Soft clear a few cycles after an edge, then the wave continues.
        wave(5, 5, 2);
        hold(1'b1, 5);
        hold(1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        hold(1'b0, 3);
        wave(5, 5, 3);

        // Long high level and single-cycle glitches.
        hold(1'b1, 50);
        hold(1'b0, 10);
        repeat (4) begin
            hold(1'b1, 1);
            hold(1'b0, $urandom_range(6, 15));
        end

        // Random levels, durations and occasional restarts.
        repeat (300) begin
            case ($urandom_range(0, 50))
                0:       applyStimulus(1'b0, 1'b1, 1'b0);
                1:       applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b1);
                default: hold(1'($urandom_range(0, 1)), $urandom_range(1, 24));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
